// File: rtl/seg7_mux_driver.sv
// seg7_mux_driver: two-digit multiplexed 7-segment driver.
// Captures an 8-bit code and converts it to BCD with a sequential
// double-dabble engine (8 shift steps plus one load cycle). The resulting
// digits are shown on a shared segment bus that alternates between the
// units and tens digits every REFRESH_COUNT cycles.
// Optional feature: define SEG7_BLANK_EN to blank a leading zero in the
// tens slot.

module seg7_mux_driver #(
    parameter logic [23:0] REFRESH_COUNT = 24'd10_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] code_in,
    input  logic       code_valid,
    output logic       code_ready,
    output logic [6:0] seg_out,
    output logic       dp_out,
    output logic [1:0] digit_en,
    output logic       overflow
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LOAD  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [7:0]  bin_sh;
    logic [11:0] bcd_acc;
    logic [2:0]  shift_cnt;
    logic        ovf_cap;
    logic [19:0] dd_step;

    logic [3:0]  tens_disp;
    logic [3:0]  units_disp;
    logic        ovf_disp;

    logic [23:0] refresh_cnt;
    logic        digit_sel;

    // Add 3 to every BCD nibble that is 5 or more, ahead of the shift.
    function automatic logic [11:0] dabble_adjust(input logic [11:0] b);
        logic [11:0] r;
        r = b;
        for (int n = 0; n < 3; n++) begin
            if (r[n*4 +: 4] >= 4'd5)
                r[n*4 +: 4] = r[n*4 +: 4] + 4'd3;
        end
        return r;
    endfunction

    // Map a decimal digit to its active-high a..g segment pattern.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    // One double-dabble iteration over the combined {bcd, binary} register.
    assign dd_step = {dabble_adjust(bcd_acc), bin_sh} << 1;

    // FSM state register; reset aborts any conversion in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic: capture, eight shift steps, then one load cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (code_valid) state_nxt = SHIFT;
            SHIFT:   if (shift_cnt == 3'd7) state_nxt = LOAD;
            LOAD:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign code_ready = (state == IDLE);

    // Shift iteration counter, cleared on capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            shift_cnt <= 3'd0;
        else if (state == IDLE && code_valid)
            shift_cnt <= 3'd0;
        else if (state == SHIFT)
            shift_cnt <= shift_cnt + 3'd1;
    end

    // Conversion datapath; contents are meaningless until the FSM loads them.
    always_ff @(posedge clk) begin
        if (state == IDLE && code_valid) begin
            bin_sh  <= code_in;
            bcd_acc <= 12'd0;
            ovf_cap <= (code_in >= 8'd100);
        end else if (state == SHIFT) begin
            bcd_acc <= dd_step[19:8];
            bin_sh  <= dd_step[7:0];
        end
    end

    // Display registers hold the last finished conversion until the next LOAD.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tens_disp  <= 4'd0;
            units_disp <= 4'd0;
            ovf_disp   <= 1'b0;
        end else if (state == LOAD) begin
            tens_disp  <= bcd_acc[7:4];
            units_disp <= bcd_acc[3:0];
            ovf_disp   <= ovf_cap;
        end
    end

    // Free-running refresh timer that flips the active digit each period.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            refresh_cnt <= 24'd0;
            digit_sel   <= 1'b0;
        end else if (refresh_cnt == REFRESH_COUNT - 24'd1) begin
            refresh_cnt <= 24'd0;
            digit_sel   <= ~digit_sel;
        end else begin
            refresh_cnt <= refresh_cnt + 24'd1;
        end
    end

    assign overflow = ovf_disp;

    // Segment bus and digit enable derived from the same select, so they switch together.
    always_comb begin
        digit_en = digit_sel ? 2'b10 : 2'b01;
        dp_out   = ovf_disp & ~digit_sel;
        if (ovf_disp)
            seg_out = 7'h40;
        else if (digit_sel) begin
`ifdef SEG7_BLANK_EN
            seg_out = (tens_disp == 4'd0) ? 7'h00 : seg_decode(tens_disp);
`else
            seg_out = seg_decode(tens_disp);
`endif
        end else
            seg_out = seg_decode(units_disp);
    end

endmodule

// File: tb/tb_seg7_mux_driver.sv
// Scoreboard bench for seg7_mux_driver with a short refresh period.
module tb_seg7_mux_driver;

    localparam int RC = 4;
    localparam logic [6:0] SEG_TAB [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                            7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] code_in;
    logic       code_valid;
    logic       code_ready;
    logic [6:0] seg_out;
    logic       dp_out;
    logic [1:0] digit_en;
    logic       overflow;

    int errors = 0;
    int checks = 0;
    int exp_q[$];

    // Reference display contents and refresh time since reset release.
    int          m_code = 0;
    int unsigned rcyc = 0;
    int          busy = 0;
    logic        prev_ready = 1'b1;

    seg7_mux_driver #(.REFRESH_COUNT(24'(RC))) dut (
        .clk        (clk),
        .reset      (reset),
        .code_in    (code_in),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .seg_out    (seg_out),
        .dp_out     (dp_out),
        .digit_en   (digit_en),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] exp_seg(input int code, input bit tens_slot);
        int t;
        int u;
        if (code >= 100) return 7'h40;
        t = code / 10;
        u = code % 10;
        if (!tens_slot) return SEG_TAB[u];
`ifdef SEG7_BLANK_EN
        if (t == 0) return 7'h00;
`endif
        return SEG_TAB[t];
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) rcyc <= 0;
        else       rcyc <= rcyc + 1;
    end

    // Monitor: pops an expected code whenever a conversion completes, checks every cycle.
    always @(negedge clk) begin
        bit sel;
        if (reset) begin
            exp_q.delete();
            m_code = 0;
            busy   = 0;
            chk("ready_in_reset", 32'(code_ready), 32'd1);
        end else begin
            if (!code_ready) begin
                busy++;
            end else if (!prev_ready) begin
                chk("busy_cycles", 32'(busy), 32'd9);
                busy = 0;
                if (exp_q.size() == 0) begin
                    errors++;
                    checks++;
                    $display("FAIL unexpected_load: got conversion expected none at %0t", $time);
                end else begin
                    m_code = exp_q.pop_front();
                end
            end
        end
        prev_ready = code_ready;
        sel = ((rcyc / RC) % 2) == 1;
        chk("digit_en", 32'(digit_en), sel ? 32'd2 : 32'd1);
        chk("seg_out", 32'(seg_out), 32'(exp_seg(m_code, sel)));
        chk("overflow", 32'(overflow), 32'(m_code >= 100));
        chk("dp_out", 32'(dp_out), 32'((m_code >= 100) && !sel));
    end

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (code_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            errors++;
            checks++;
            $display("FAIL ready_timeout: got code_ready=0 expected 1 within 40 cycles");
        end
    endtask

    task automatic send(input int c);
        bit ok;
        wait_ready(ok);
        if (ok) begin
            code_in    = 8'(c);
            code_valid = 1'b1;
            exp_q.push_back(c);
            @(posedge clk); #1;
            code_valid = 1'b0;
        end
    endtask

    // Hold code_valid high across a conversion so the second code lands at E9+1.
    task automatic send_held(input int a, input int b);
        bit ok;
        wait_ready(ok);
        if (ok) begin
            code_in    = 8'(a);
            code_valid = 1'b1;
            exp_q.push_back(a);
            @(posedge clk); #1;
            code_in = 8'(b);
            wait_ready(ok);
            if (ok) exp_q.push_back(b);
            @(posedge clk); #1;
            code_valid = 1'b0;
        end
    endtask

    // One-cycle strobe while busy; the DUT must ignore it.
    task automatic ignore_pulse(input int c);
        if (!code_ready) begin
            code_in    = 8'(c);
            code_valid = 1'b1;
            @(posedge clk); #1;
            code_valid = 1'b0;
        end
    endtask

    initial begin
        bit ok;
        reset      = 1'b1;
        code_valid = 1'b0;
        code_in    = 8'd0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        send(17);
        send(5);
        send(150);
        send(10);
        send(0);
        send(99);
        send(100);
        send(255);

        send(42);
        repeat (2) @(posedge clk);
        #1 ignore_pulse(77);

        send_held(33, 64);

        send(88);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);

        for (int n = 0; n < 200; n++) begin
            int c;
            c = ($urandom_range(0, 3) == 0) ? int'($urandom_range(95, 255)) : int'($urandom_range(0, 99));
            if ($urandom_range(0, 9) == 0) begin
                send_held(c, int'($urandom_range(0, 255)));
            end else begin
                send(c);
                if ($urandom_range(0, 2) == 0) begin
                    repeat ($urandom_range(0, 6)) @(posedge clk);
                    #1 ignore_pulse(int'($urandom_range(0, 255)));
                end
            end
            repeat ($urandom_range(0, 12)) @(posedge clk);
            #1;
        end

        wait_ready(ok);
        repeat (3) @(posedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
